// File: rtl/mpu_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : mpu_spi_master
// Description : SPI mode-3 master for MPU-style register access. Each frame
//               is 16 bits, MSB first: {rd_wr_sel, address[6:0], data}, where
//               data is wr_data for writes and 8'h00 for reads. For reads,
//               the byte returned in the second half of the frame is placed
//               on rd_data.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               start               - frame request (accepted in IDLE only)
//               rd_wr_sel           - 1 = read, 0 = write
//               address[6:0]        - register address
//               wr_data[7:0]        - write payload
//               rd_data[7:0]        - last byte read
//               busy                - transaction in progress
//               done                - one-cycle pulse on the last gap cycle
//               SPI_SS_a            - slave select, active low (registered)
//               SPI_CK_a            - SPI clock, idle high (registered)
//               SPI_DO_a            - master out (registered)
//               SPI_DI_a            - master in
// Revision    : 1.0 - initial release
// ============================================================================
module mpu_spi_master #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rd_wr_sel,
    input  logic [6:0] address,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       SPI_SS_a,
    output logic       SPI_CK_a,
    output logic       SPI_DO_a,
    input  logic       SPI_DI_a
);

    // One counter times both the SCK phases and the inter-frame gap.
    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_CK_LOW  = 3'd2;
    localparam logic [2:0] S_CK_HIGH = 3'd3;
    localparam logic [2:0] S_HOLD    = 3'd4;
    localparam logic [2:0] S_GAP     = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [15:0]      tx_q, tx_d;
    logic [15:0]      rx_q, rx_d;
    logic [7:0]       rd_q, rd_d;
    logic             rw_q, rw_d;
    logic             ss_q, ss_d;
    logic             ck_q, ck_d;
    logic             do_q, do_d;
    logic             phase_end;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rd_q    <= 8'h00;
            rw_q    <= 1'b0;
            ss_q    <= 1'b1;
            ck_q    <= 1'b1;
            do_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rd_q    <= rd_d;
            rw_q    <= rw_d;
            ss_q    <= ss_d;
            ck_q    <= ck_d;
            do_q    <= do_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rd_d      = rd_q;
        rw_d      = rw_q;
        phase_end = (cnt_q == DIV_LAST);
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_SETUP;
                    bit_d   = '0;
                    rw_d    = rd_wr_sel;
                    tx_d    = {rd_wr_sel, address, rd_wr_sel ? 8'h00 : wr_data};
                end
            end
            S_SETUP: begin
                if (phase_end) begin
                    state_d = S_CK_LOW;
                    cnt_d   = '0;
                end
            end
            S_CK_LOW: begin
                // The edge that raises SCK is the sampling point for MISO.
                if (phase_end) begin
                    state_d = S_CK_HIGH;
                    cnt_d   = '0;
                    rx_d    = {rx_q[14:0], SPI_DI_a};
                end
            end
            S_CK_HIGH: begin
                if (phase_end) begin
                    cnt_d = '0;
                    if (bit_q == 4'd15) begin
                        state_d = S_HOLD;
                        if (rw_q) begin
                            rd_d = rx_q[7:0];
                        end
                    end else begin
                        state_d = S_CK_LOW;
                        bit_d   = bit_q + 4'd1;
                        tx_d    = {tx_q[14:0], 1'b0};
                    end
                end
            end
            S_HOLD: begin
                if (phase_end) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic. The pin registers are loaded from the next-state
    // decode so that they line up with state_q without a cycle of lag.
    always_comb begin
        ss_d = 1'b1;
        ck_d = 1'b1;
        do_d = 1'b0;
        case (state_d)
            S_SETUP:   begin ss_d = 1'b0; do_d = tx_d[15]; end
            S_CK_LOW:  begin ss_d = 1'b0; ck_d = 1'b0; do_d = tx_d[15]; end
            S_CK_HIGH: begin ss_d = 1'b0; do_d = tx_d[15]; end
            S_HOLD:    begin ss_d = 1'b0; end
            default:   begin ss_d = 1'b1; end
        endcase
        done = (state_q == S_GAP) && (cnt_q == GAP_LAST);
        busy = !reset && ((state_q != S_IDLE) || start);
    end

    assign rd_data  = rd_q;
    assign SPI_SS_a = ss_q;
    assign SPI_CK_a = ck_q;
    assign SPI_DO_a = do_q;

endmodule
`default_nettype wire

// File: tb/tb_mpu_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_mpu_spi_master
// Description : Self-checking bench for mpu_spi_master. Instance 0 uses the
//               default timing, instance 1 uses CLK_DIV=2, GAP_CYCLES=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mpu_spi_master;

    typedef struct {
        logic        rw;
        logic [6:0]  addr;
        logic [7:0]  wr;
        logic [7:0]  slave;
        logic        poke;
        logic [15:0] exp_do;
        logic [7:0]  exp_rd;
    } vec_t;

    logic       clk;
    logic       rst   [2];
    logic       start [2];
    logic       rw    [2];
    logic [6:0] addr  [2];
    logic [7:0] wr    [2];
    logic [7:0] rd    [2];
    logic       busy  [2];
    logic       done  [2];
    logic       ss    [2];
    logic       ck    [2];
    logic       dout  [2];
    logic       di    [2];

    logic [15:0] slave_w    [2];
    logic [15:0] sh         [2];
    logic [15:0] cap        [2];
    logic [15:0] last_cap   [2];
    int          edges      [2];
    int          last_edges [2];
    time         t0         [2];
    time         t1         [2];
    logic        prev_ss    [2];
    logic        prev_ck    [2];

    int   n_pass;
    int   n_tot;
    vec_t vecs [4];

    mpu_spi_master u_dut0 (
        .clk(clk), .reset(rst[0]), .start(start[0]), .rd_wr_sel(rw[0]),
        .address(addr[0]), .wr_data(wr[0]), .rd_data(rd[0]), .busy(busy[0]),
        .done(done[0]), .SPI_SS_a(ss[0]), .SPI_CK_a(ck[0]), .SPI_DO_a(dout[0]),
        .SPI_DI_a(di[0])
    );

    mpu_spi_master #(.CLK_DIV(2), .GAP_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(rst[1]), .start(start[1]), .rd_wr_sel(rw[1]),
        .address(addr[1]), .wr_data(wr[1]), .rd_data(rd[1]), .busy(busy[1]),
        .done(done[1]), .SPI_SS_a(ss[1]), .SPI_CK_a(ck[1]), .SPI_DO_a(dout[1]),
        .SPI_DI_a(di[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mode-3 slave and MOSI monitor for both instances, sampled mid-cycle.
    initial begin
        for (int g = 0; g < 2; g++) begin
            prev_ss[g] = 1'b1; prev_ck[g] = 1'b1; di[g] = 1'b0;
            sh[g] = '0; cap[g] = '0; last_cap[g] = '0;
            edges[g] = 0; last_edges[g] = 0; t0[g] = 0; t1[g] = 0;
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (prev_ss[g] && !ss[g]) begin
                sh[g] = slave_w[g]; cap[g] = '0; edges[g] = 0;
            end
            if (!prev_ss[g] && ss[g]) begin
                last_cap[g] = cap[g]; last_edges[g] = edges[g];
            end
            if (!ss[g] && prev_ck[g] && !ck[g]) begin
                di[g] = sh[g][15];
                sh[g] = {sh[g][14:0], 1'b0};
            end
            if (!ss[g] && !prev_ck[g] && ck[g]) begin
                if (edges[g] == 0) t0[g] = $time;
                if (edges[g] == 1) t1[g] = $time;
                cap[g]   = {cap[g][14:0], dout[g]};
                edges[g] = edges[g] + 1;
            end
            prev_ss[g] = ss[g];
            prev_ck[g] = ck[g];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // Runs one frame on instance g and checks stream, timing and results.
    task automatic run_vec(input int g, input vec_t v, input int exp_busy);
        int nb, nd, to, lows;
        logic [7:0] rdd;
        slave_w[g] = {~v.slave, v.slave};
        @(negedge clk);
        rw[g] = v.rw; addr[g] = v.addr; wr[g] = v.wr; start[g] = 1'b1;
        #1;
        chk("busy_in_start_cycle", busy[g], 1);
        nb = 1; nd = 0; to = 1; rdd = 8'hxx;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start[g] = 1'b0; rw[g] = ~v.rw; addr[g] = 7'h55; wr[g] = 8'hFF;
            end
            if (v.poke && i == 40) begin start[g] = 1'b1; addr[g] = 7'h3B; end
            if (v.poke && i == 41) start[g] = 1'b0;
            #1;
            if (!busy[g]) begin to = 0; break; end
            nb++;
            if (done[g]) begin nd++; rdd = rd[g]; end
        end
        chk("frame_timeout", to, 0);
        chk("busy_cycles", nb, exp_busy);
        chk("done_pulses", nd, 1);
        chk("rd_data_at_done", rdd, v.exp_rd);
        chk("mosi_stream", last_cap[g], v.exp_do);
        chk("sck_rising_edges", last_edges[g], 16);
        if (v.poke) begin
            lows = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk); #1;
                if (!ss[g] || busy[g]) lows++;
            end
            chk("no_queued_frame", lows, 0);
        end
    endtask

    initial begin
        int   n, to, nd;
        logic [15:0] cap1;
        vec_t v;
        n_pass = 0; n_tot = 0;

        vecs[0].rw = 1'b0; vecs[0].addr = 7'h6B; vecs[0].wr = 8'h00; vecs[0].slave = 8'hEE;
        vecs[0].poke = 1'b0; vecs[0].exp_do = 16'h6B00; vecs[0].exp_rd = 8'h00;
        vecs[1].rw = 1'b1; vecs[1].addr = 7'h75; vecs[1].wr = 8'h12; vecs[1].slave = 8'h71;
        vecs[1].poke = 1'b0; vecs[1].exp_do = 16'hF500; vecs[1].exp_rd = 8'h71;
        vecs[2].rw = 1'b0; vecs[2].addr = 7'h1A; vecs[2].wr = 8'h5C; vecs[2].slave = 8'h00;
        vecs[2].poke = 1'b1; vecs[2].exp_do = 16'h1A5C; vecs[2].exp_rd = 8'h71;
        vecs[3].rw = 1'b1; vecs[3].addr = 7'h3B; vecs[3].wr = 8'hAA; vecs[3].slave = 8'hC3;
        vecs[3].poke = 1'b0; vecs[3].exp_do = 16'hBB00; vecs[3].exp_rd = 8'hC3;

        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b1; start[g] = 1'b0; rw[g] = 1'b0; addr[g] = '0; wr[g] = '0;
            slave_w[g] = '0;
        end

        // Reset, with start asserted during reset to show reset wins.
        repeat (2) @(negedge clk);
        start[0] = 1'b1; #1;
        chk("busy_during_reset", busy[0], 0);
        @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0; start[0] = 1'b0; #1;
        for (int g = 0; g < 2; g++) begin
            chk("reset_ss", ss[g], 1);
            chk("reset_ck", ck[g], 1);
            chk("reset_do", dout[g], 0);
            chk("reset_busy", busy[g], 0);
            chk("reset_done", done[g], 0);
            chk("reset_rd_data", rd[g], 8'h00);
        end

        for (int i = 0; i < 4; i++) run_vec(0, vecs[i], 145);
        chk("sck_period_div4", 32'(t1[0] - t0[0]), 80);

        // Back-to-back frames with start held high.
        @(negedge clk);
        rw[0] = 1'b0; addr[0] = 7'h1A; wr[0] = 8'h5C; start[0] = 1'b1;
        to = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (!ss[0]) begin to = 0; break; end
        end
        chk("b2b_first_ss_timeout", to, 0);
        addr[0] = 7'h22; wr[0] = 8'h99;
        to = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (ss[0]) begin to = 0; break; end
        end
        chk("b2b_gap_timeout", to, 0);
        cap1 = last_cap[0];
        n = 0;
        for (int i = 0; i < 50; i++) begin
            if (!ss[0]) break;
            n++;
            @(negedge clk); #1;
        end
        start[0] = 1'b0;
        chk("b2b_ss_high_cycles", n, 9);
        chk("b2b_frame1", cap1, 16'h1A5C);
        to = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (!busy[0]) begin to = 0; break; end
        end
        chk("b2b_end_timeout", to, 0);
        chk("b2b_frame2", last_cap[0], 16'h2299);
        chk("b2b_frame2_edges", last_edges[0], 16);

        // Reset in the middle of a read, during bit 7.
        slave_w[0] = 16'h00FF;
        @(negedge clk);
        rw[0] = 1'b1; addr[0] = 7'h3B; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        to = 1;
        for (int i = 0; i < 400; i++) begin
            #1;
            if (edges[0] == 7) begin to = 0; break; end
            @(negedge clk);
        end
        chk("abort_wait_timeout", to, 0);
        @(negedge clk);
        rst[0] = 1'b1; #1;
        chk("abort_busy_in_reset", busy[0], 0);
        @(negedge clk);
        rst[0] = 1'b0; #1;
        chk("abort_ss", ss[0], 1);
        chk("abort_ck", ck[0], 1);
        chk("abort_do", dout[0], 0);
        chk("abort_busy", busy[0], 0);
        chk("abort_rd_cleared", rd[0], 8'h00);
        nd = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (done[0] || !ss[0]) nd++;
        end
        chk("abort_no_done", nd, 0);

        v.rw = 1'b1; v.addr = 7'h3B; v.wr = 8'h00; v.slave = 8'hA5;
        v.poke = 1'b0; v.exp_do = 16'hBB00; v.exp_rd = 8'hA5;
        run_vec(0, v, 145);

        // Fast instance: CLK_DIV=2, GAP_CYCLES=1.
        v.rw = 1'b1; v.addr = 7'h75; v.wr = 8'h00; v.slave = 8'h3C;
        v.poke = 1'b0; v.exp_do = 16'hF500; v.exp_rd = 8'h3C;
        run_vec(1, v, 70);
        chk("sck_period_div2", 32'(t1[1] - t0[1]), 40);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
